// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit_if : instruction-memory and IF/ID bundle for fetch_unit    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, pc_out,
    input  imem_ack, imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, pc_out,
    output imem_ack, imem_rdata, stall, redirect, redirect_pc
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit : single-outstanding-request fetcher with 2-entry buffer   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clock,
  input  logic         reset_n,
  fetch_unit_if.master bus
);

  localparam logic [0:0] ST_NORMAL  = 1'b0;
  localparam logic [0:0] ST_DISCARD = 1'b1;

  logic [0:0]  r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_req_addr;
  logic        r_pending;
  logic [1:0]  r_count;
  logic [31:0] r_pc0, r_pc1, r_ins0, r_ins1;

  logic w_req;
  logic w_push;
  logic w_pop;
  logic w_unused_rpc;

  always_comb begin
    w_req  = r_pending || ((r_state == ST_NORMAL) && (r_count < 2'd2));
    w_push = w_req && bus.imem_ack && (r_state == ST_NORMAL) && !bus.redirect;
    w_pop  = (r_count != 2'd0) && !bus.stall && !bus.redirect;
  end

  // reset_n only gates the port so it never feeds back into a flop input
  assign bus.imem_req    = reset_n && w_req;
  // while discarding, the abandoned request must keep its original address
  assign bus.imem_addr   = (r_state == ST_DISCARD) ? r_req_addr : r_fetch_pc;
  assign bus.instr_valid = (r_count != 2'd0);
  assign bus.instr_out   = r_ins0;
  assign bus.pc_out      = r_pc0;
  assign w_unused_rpc    = ^bus.redirect_pc[1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_NORMAL;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_pending  <= 1'b0;
    end else begin
      r_pending <= w_req && !bus.imem_ack;
      if (bus.redirect) begin
        r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
        if ((r_state == ST_NORMAL) && w_req && !bus.imem_ack) begin
          r_state    <= ST_DISCARD;
          r_req_addr <= r_fetch_pc;
        end else if ((r_state == ST_DISCARD) && bus.imem_ack) begin
          r_state <= ST_NORMAL;
        end
      end else begin
        if ((r_state == ST_DISCARD) && bus.imem_ack) begin
          r_state <= ST_NORMAL;
        end
        if (w_push) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
      end
    end
  end

  // Shift-style buffer: entry 0 is always the head, so an emptied buffer
  // naturally keeps presenting the last head entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= 2'd0;
      r_pc0   <= 32'd0;
      r_pc1   <= 32'd0;
      r_ins0  <= 32'd0;
      r_ins1  <= 32'd0;
    end else if (bus.redirect) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          r_count <= r_count + 2'd1;
          if (r_count == 2'd0) begin
            r_pc0  <= r_fetch_pc;
            r_ins0 <= bus.imem_rdata;
          end else begin
            r_pc1  <= r_fetch_pc;
            r_ins1 <= bus.imem_rdata;
          end
        end
        2'b01: begin
          r_count <= r_count - 2'd1;
          if (r_count == 2'd2) begin
            r_pc0  <= r_pc1;
            r_ins0 <= r_ins1;
          end
        end
        2'b11: begin
          if (r_count == 2'd2) begin
            r_pc0  <= r_pc1;
            r_ins0 <= r_ins1;
            r_pc1  <= r_fetch_pc;
            r_ins1 <= bus.imem_rdata;
          end else begin
            r_pc0  <= r_fetch_pc;
            r_ins0 <= bus.imem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_unit : directed and random checks of fetch_unit vs a model   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_fetch_unit;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  fetch_unit_if bus0();
  fetch_unit_if bus1();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (.clock(clock), .reset_n(reset_n), .bus(bus0));
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut1 (.clock(clock), .reset_n(reset_n), .bus(bus1));

  // second instance: zero-wait memory returning its own address
  assign bus1.imem_ack    = 1'b1;
  assign bus1.imem_rdata  = bus1.imem_addr;
  assign bus1.stall       = 1'b0;
  assign bus1.redirect    = 1'b0;
  assign bus1.redirect_pc = 32'd0;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] salt = 32'd0;

  // reference model: fetch address, one-outstanding flag, discard flag, queue
  logic [31:0] m_pc;
  logic        m_pend;
  logic        m_disc;
  logic [31:0] m_old;
  logic [63:0] m_q[$];
  logic [63:0] m_last;

  logic [31:0] p1[3];
  logic [31:0] i1[3];
  int          n1 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic m_req();
    return m_pend || (!m_disc && (m_q.size() < 2));
  endfunction

  function automatic logic [31:0] m_addr();
    return m_disc ? m_old : m_pc;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ salt;
  endfunction

  task automatic model_reset();
    m_pc   = 32'd0;
    m_pend = 1'b0;
    m_disc = 1'b0;
    m_old  = 32'd0;
    m_q.delete();
    m_last = 64'd0;
  endtask

  task automatic model_step(input logic ack, input logic stl, input logic rd,
                            input logic [31:0] rpc, input logic [31:0] rdata);
    logic req;
    req = m_req();
    if (m_q.size() != 0) m_last = m_q[0];
    if (rd) begin
      if (!m_disc && req && !ack) begin
        m_disc = 1'b1;
        m_old  = m_pc;
      end else if (m_disc && ack) begin
        m_disc = 1'b0;
      end
      m_q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else if (m_disc) begin
      if (ack) m_disc = 1'b0;
    end else begin
      if (m_q.size() != 0 && !stl) m_last = m_q.pop_front();
      if (req && ack) begin
        m_q.push_back({m_pc, rdata});
        m_pc = m_pc + 32'd4;
      end
    end
    m_pend = req && !ack;
    if (m_q.size() != 0) m_last = m_q[0];
  endtask

  // Enter at a falling edge; compare, drive, let the rising edge happen, step.
  task automatic cycle(input logic ack, input logic stl, input logic rd, input logic [31:0] rpc);
    logic [63:0] h;
    logic [31:0] rdata;
    #1;
    h = (m_q.size() != 0) ? m_q[0] : m_last;
    chk("instr_valid", 32'(bus0.instr_valid), 32'(m_q.size() != 0));
    chk("pc_out", bus0.pc_out, h[63:32]);
    chk("instr_out", bus0.instr_out, h[31:0]);
    chk("imem_req", 32'(bus0.imem_req), 32'(m_req()));
    if (m_req()) chk("imem_addr", bus0.imem_addr, m_addr());
    rdata = mem_word(m_addr());
    bus0.imem_ack    = ack;
    bus0.stall       = stl;
    bus0.redirect    = rd;
    bus0.redirect_pc = rpc;
    bus0.imem_rdata  = rdata;
    @(posedge clock);
    model_step(ack, stl, rd, rpc, rdata);
    @(negedge clock);
  endtask

  task automatic do_reset(input int cycles);
    reset_n          = 1'b0;
    bus0.imem_ack    = 1'b1;
    bus0.stall       = 1'b0;
    bus0.redirect    = 1'b0;
    bus0.redirect_pc = 32'd0;
    bus0.imem_rdata  = 32'hDEAD_BEEF;
    #1;
    chk("rst_req", 32'(bus0.imem_req), 32'd0);
    chk("rst_valid", 32'(bus0.instr_valid), 32'd0);
    chk("rst_instr", bus0.instr_out, 32'd0);
    chk("rst_pc", bus0.pc_out, 32'd0);
    chk("rst_addr", bus0.imem_addr, 32'd0);
    chk("rst_addr1", bus1.imem_addr, 32'hFFFF_FFF8);
    chk("rst_req1", 32'(bus1.imem_req), 32'd0);
    model_reset();
    repeat (cycles) @(negedge clock);
    reset_n = 1'b1;
  endtask

  always @(negedge clock) begin
    if (reset_n && bus1.instr_valid && n1 < 3) begin
      p1[n1] = bus1.pc_out;
      i1[n1] = bus1.instr_out;
      n1++;
    end
  end

  initial begin
    bus0.imem_ack    = 1'b0;
    bus0.stall       = 1'b0;
    bus0.redirect    = 1'b0;
    bus0.redirect_pc = 32'd0;
    bus0.imem_rdata  = 32'd0;
    model_reset();
    @(negedge clock);

    // streaming with zero-wait memory
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
      chk("seq_valid", 32'(bus0.instr_valid), 32'd1);
      chk("seq_pc", bus0.pc_out, 32'(4 * i));
      chk("seq_instr", bus0.instr_out, 32'(4 * i));
    end

    // stall fills the buffer, release drains without gap or repeat
    do_reset(1);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    repeat (5) cycle(1'b1, 1'b1, 1'b0, 32'd0);
    chk("stall_pc", bus0.pc_out, 32'd0);
    chk("stall_req", 32'(bus0.imem_req), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("release_pc4", bus0.pc_out, 32'd4);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("release_pc8", bus0.pc_out, 32'd8);

    // redirect during a slow request
    do_reset(1);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0103);
    chk("disc_addr", bus0.imem_addr, 32'd0);
    chk("disc_req", 32'(bus0.imem_req), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    chk("disc_addr2", bus0.imem_addr, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("disc_drop", 32'(bus0.instr_valid), 32'd0);
    chk("disc_newaddr", bus0.imem_addr, 32'h100);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("disc_first_pc", bus0.pc_out, 32'h100);

    // redirect with a full buffer
    do_reset(1);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    chk("full_pc", bus0.pc_out, 32'd8);
    chk("full_req", 32'(bus0.imem_req), 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 32'h40);
    chk("flush_valid", 32'(bus0.instr_valid), 32'd0);
    chk("flush_addr", bus0.imem_addr, 32'h40);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("flush_pc", bus0.pc_out, 32'h40);

    // reset pulse with one entry held and a request outstanding
    do_reset(1);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'd0);
    chk("pre_rst_valid", 32'(bus0.instr_valid), 32'd1);
    chk("pre_rst_req", 32'(bus0.imem_req), 32'd1);
    do_reset(1);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    chk("post_rst_addr", bus0.imem_addr, 32'd0);
    chk("post_rst_valid", 32'(bus0.instr_valid), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("post_rst_pc", bus0.pc_out, 32'd0);

    // randomized traffic against the model
    salt = 32'h5A5A_C3C3;
    do_reset(1);
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset(1);
      end else begin
        cycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
              $urandom_range(0, 19) == 0, $urandom);
      end
    end

    // wrap-around from the high reset address
    chk("wrap_pc0", p1[0], 32'hFFFF_FFF8);
    chk("wrap_pc1", p1[1], 32'hFFFF_FFFC);
    chk("wrap_pc2", p1[2], 32'h0000_0000);
    chk("wrap_instr2", i1[2], 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
